maclaurin_job_issuer: RTL and testbench
=======================================

Name: maclaurin_job_issuer

Overview:
- Initiator side of the start/done handshake used by the Maclaurin series controller units (ln, exp, ...).
- Accepts an operand on a valid/ready request port and drives the unit's start and xin.
- Detects job completion from done, then returns the unit's result on a valid/ready response port.
- Sits between the top-level host/test harness and one series datapath+controller pair.

Parameters:
- W, 16, operand/result width (fixed-point bits).
- START_CYCLES, 2, cycles start is held high per job (>=1).
- TIMEOUT, 64, max cycles from start release to done re-assertion before abort (>=4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  host offers an operand.
- req_ready  out  1  issuer accepts an operand this cycle.
- req_x  in  W  operand.
- start  out  1  start to series controller.
- xin  out  W  operand to series datapath; held stable for the whole job.
- done  in  1  series controller idle flag (high in its IDLE state).
- result  in  W  series datapath result; valid when done re-asserts.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_data  out  W  captured result, or 0 on timeout.
- rsp_timeout  out  1  qualifies rsp_data: job aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async) sets state to IDLE and clears all registered outputs: start=0, xin=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, timer=0. req_ready=1 after reset, because it is combinational in IDLE.
- The controller protocol is fixed. The unit leaves IDLE on start=1, waits for start=0, and only then loads xin. done is 1 only in the unit's IDLE state.
- IDLE: req_ready=1. On req_valid&req_ready, register xin<=req_x and go to SYNC.
- SYNC: wait until done=1, so the unit is idle before start is raised. Then go to START_HI with the counter cleared.
- START_HI: start=1 for exactly START_CYCLES cycles, then go to START_LO with the timer cleared.
- START_LO: start=0. Wait for done=0, which means the unit has accepted the job. Then go to RUN.
- RUN: wait for done=1. On that cycle capture rsp_data<=result, set rsp_timeout<=0, and go to RESP.
- Timer: runs in START_LO and RUN. When it reaches TIMEOUT-1 with no exit condition, set rsp_data<=0, rsp_timeout<=1, and go to RESP. A done edge on the same cycle as the timer expiring wins; the job is not reported as a timeout.
- RESP: rsp_valid=1, holding rsp_data and rsp_timeout stable. On rsp_ready, clear rsp_valid and return to IDLE. req_ready stays 0 in RESP, so at most one job is outstanding.
- xin holds its value from acceptance until the next acceptance. It is never cleared by job completion.
- Latency: accept -> start rise takes 1 cycle when done=1 at acceptance. Response appears 1 cycle after the done rising edge.
- Reset mid-job aborts immediately with outputs at their reset values. The series unit is expected to share the reset.
- SYNC has no timeout. A stuck unit keeps busy=1.

Optional Feature:
- Macro: MACLAURIN_ISSUER_STATS_EN.
- Defined: adds two outputs, jobs_done [15:0] and jobs_timeout [15:0].
  - Each increments on entry to RESP, according to rsp_timeout.
  - Each saturates at 16'hFFFF and is cleared by reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package maclaurin_pkg holds:
  - the issuer state enum (IDLE, SYNC, START_HI, START_LO, RUN, RESP);
  - the default operand width constant;
  - the default TIMEOUT and START_CYCLES constants.
- One sub-module, cycle_timer: a parameterised up-counter with clear, enable and terminal-count output. It is used for both the START_CYCLES count and the TIMEOUT count.

Test Plan:
- Normal job: req_x=16'h0100 with a behavioural ln controller model (done drops 1 cycle after start falls, rises 20 cycles later, result=16'h00B1). Required: start high exactly 2 cycles, xin=16'h0100 throughout, rsp_valid with rsp_data=16'h00B1 and rsp_timeout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_valid and rsp_data stable, req_ready=0. A req_valid offered during RESP is not accepted until after the handshake.
- Timeout: model never drops done after start. Required: rsp_valid with rsp_timeout=1 and rsp_data=0 exactly TIMEOUT cycles after start falls. The next job then proceeds normally.
- Busy unit at accept: done=0 for 5 cycles after acceptance. Required: start stays 0 in SYNC and rises 1 cycle after done=1.
- Reset mid-RUN: pulse rst=0 for 1 cycle. Required: start=0, rsp_valid=0, busy=0 asynchronously, and req_ready=1 after release.
- Stats (MACLAURIN_ISSUER_STATS_EN): 3 normal jobs and 1 timeout give jobs_done=3 and jobs_timeout=1.

Source files
------------

// File: rtl/maclaurin_pkg.sv
// rtl/maclaurin_pkg.sv - shared types and defaults for the Maclaurin series job issuer
package maclaurin_pkg;

  localparam int DEF_W            = 16;
  localparam int DEF_START_CYCLES = 2;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START_HI,
    START_LO,
    RUN,
    RESP
  } issuer_state_t;

endpackage

// File: rtl/maclaurin_job_issuer_if.sv
// rtl/maclaurin_job_issuer_if.sv - host request/response handshake bundle for the job issuer
interface maclaurin_job_issuer_if
  import maclaurin_pkg::*;
#(
  parameter int W = DEF_W
) ();

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_x;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_timeout;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - up-counter with clear and enable; tc flags count == N-1 and holds there
module cycle_timer #(
  parameter int N = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/maclaurin_job_issuer.sv
// rtl/maclaurin_job_issuer.sv - start/done job initiator for one series unit; MACLAURIN_ISSUER_STATS_EN adds job counters
module maclaurin_job_issuer
  import maclaurin_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  maclaurin_job_issuer_if.slave host,
  output logic                  start,
  output logic [W-1:0]          xin,
  input  logic                  done,
  input  logic [W-1:0]          result,
  output logic                  busy
`ifdef MACLAURIN_ISSUER_STATS_EN
  ,
  output logic [15:0]           jobs_done,
  output logic [15:0]           jobs_timeout
`endif
);

  issuer_state_t state;
  logic          start_tc;
  logic          to_tc;
  logic          job_ok;
  logic          job_abort;

  assign host.req_ready = (state == IDLE);
  assign busy           = (state != IDLE);

  cycle_timer #(.N(START_CYCLES)) u_start_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != START_HI),
    .en    (1'b1),
    .tc    (start_tc)
  );

  cycle_timer #(.N(TIMEOUT)) u_timeout_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!(state == START_LO || state == RUN)),
    .en    (1'b1),
    .tc    (to_tc)
  );

  // A done edge on the expiry cycle still counts as a good completion.
  assign job_ok    = (state == RUN) && done;
  assign job_abort = to_tc && (((state == START_LO) && done) || ((state == RUN) && !done));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      start            <= 1'b0;
      xin              <= '0;
      host.rsp_valid   <= 1'b0;
      host.rsp_data    <= '0;
      host.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            xin   <= host.req_x;
            state <= SYNC;
          end
        end
        SYNC: begin
          if (done) begin
            start <= 1'b1;
            state <= START_HI;
          end
        end
        START_HI: begin
          if (start_tc) begin
            start <= 1'b0;
            state <= START_LO;
          end
        end
        START_LO, RUN: begin
          if (state == START_LO && !done) begin
            state <= RUN;
          end else if (job_ok) begin
            host.rsp_data    <= result;
            host.rsp_timeout <= 1'b0;
            host.rsp_valid   <= 1'b1;
            state            <= RESP;
          end else if (job_abort) begin
            host.rsp_data    <= '0;
            host.rsp_timeout <= 1'b1;
            host.rsp_valid   <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MACLAURIN_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jobs_done    <= '0;
      jobs_timeout <= '0;
    end else begin
      if (job_ok && jobs_done != 16'hFFFF) begin
        jobs_done <= jobs_done + 16'd1;
      end
      if (job_abort && jobs_timeout != 16'hFFFF) begin
        jobs_timeout <= jobs_timeout + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_maclaurin_job_issuer.sv
// tb/tb_maclaurin_job_issuer.sv - scoreboard bench for the job issuer with a behavioural series controller model
`timescale 1ns/1ps
module tb_maclaurin_job_issuer;

  localparam int W  = 16;
  localparam int SC = 2;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start;
  logic [W-1:0] xin;
  logic         done = 1'b1;
  logic [W-1:0] result = '0;
  logic         busy;
`ifdef MACLAURIN_ISSUER_STATS_EN
  logic [15:0]  jobs_done;
  logic [15:0]  jobs_timeout;
`endif

  maclaurin_job_issuer_if #(.W(W)) host ();

  maclaurin_job_issuer #(.W(W), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host),
    .start        (start),
    .xin          (xin),
    .done         (done),
    .result       (result),
    .busy         (busy)
`ifdef MACLAURIN_ISSUER_STATS_EN
    ,
    .jobs_done    (jobs_done),
    .jobs_timeout (jobs_timeout)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  int           mode  = 0;   // 0: done driven by the test, 1: ln controller model
  int           mph   = 0;
  int           mcnt  = 0;
  logic [W-1:0] cur_x = '0;
  logic         prev_start = 1'b0;
  int           hi_len = 0;

  // ln controller model: done drops once start falls, rises 20 cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      mph = 0;
    end else if (mode == 1) begin
      case (mph)
        0: if (start) mph = 1;
        1: if (!start) begin done = 1'b0; mcnt = 0; mph = 2; end
        default: begin
          mcnt++;
          if (mcnt == 20) begin done = 1'b1; mph = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      hi_len     = 0;
      prev_start = 1'b0;
    end else begin
      if (start) begin
        hi_len++;
      end else if (prev_start) begin
        n_cmp++;
        if (hi_len !== SC) begin
          n_err++;
          $display("FAIL start_width: got %0d cycles want %0d", hi_len, SC);
        end
        n_cmp++;
        if (xin !== cur_x) begin
          n_err++;
          $display("FAIL xin_hold: got %h want %h", xin, cur_x);
        end
        hi_len = 0;
      end
      prev_start = start;
    end
  end

  task automatic issue(input logic [W-1:0] x);
    int t = 0;
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_x     = x;
    while (!host.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL accept_wait: req_ready never 1 within %0d cycles", t);
    end
    @(negedge clk);
    host.req_valid = 1'b0;
    cur_x = x;
    n_cmp++;
    if (xin !== x) begin
      n_err++;
      $display("FAIL accept_xin: got %h want %h", xin, x);
    end
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = 0;
    while (!host.rsp_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!host.rsp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles want 1", cyc);
    end
  endtask

  task automatic wait_start_fall();
    int t = 0;
    while (!start && t < 100) begin @(negedge clk); t++; end
    while (start && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL start_wait: start=%b after %0d cycles want a full pulse", start, t);
    end
  endtask

  task automatic take_rsp(input string name);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_sb: response with empty scoreboard got %h", name, {host.rsp_timeout, host.rsp_data});
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({host.rsp_valid, host.rsp_timeout, host.rsp_data} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL %s_rsp: got v=%b to=%b d=%h want v=1 to=%b d=%h", name,
                 host.rsp_valid, host.rsp_timeout, host.rsp_data, e[W], e[W-1:0]);
      end
    end
    host.rsp_ready = 1'b1;
    @(negedge clk);
    host.rsp_ready = 1'b0;
    n_cmp++;
    if (host.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_clear: rsp_valid got %b want 0", name, host.rsp_valid);
    end
  endtask

  task automatic run_normal(input logic [W-1:0] x, input logic [W-1:0] r, input string name);
    int cyc;
    mode   = 1;
    result = r;
    exp_q.push_back({1'b0, r});
    issue(x);
    wait_rsp(200, cyc);
    take_rsp(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({start, xin, host.rsp_valid, host.rsp_data, host.rsp_timeout, busy, host.req_ready} !==
        {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: start=%b xin=%h rv=%b rd=%h rt=%b busy=%b rr=%b want 0 0 0 0 0 0 1",
               start, xin, host.rsp_valid, host.rsp_data, host.rsp_timeout, busy, host.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({host.req_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: req_ready=%b busy=%b want 1 0", host.req_ready, busy);
    end
  endtask

  task automatic test_normal();
    run_normal(16'h0100, 16'h00B1, "normal");
    n_cmp++;
    if (xin !== 16'h0100) begin
      n_err++;
      $display("FAIL normal_xin_after: got %h want 0100", xin);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    mode   = 1;
    result = 16'h00C3;
    exp_q.push_back({1'b0, 16'h00C3});
    issue(16'h0150);
    wait_rsp(200, cyc);
    host.req_valid = 1'b1;
    host.req_x     = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({host.rsp_valid, host.req_ready, host.rsp_data} !== {1'b1, 1'b0, 16'h00C3}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: rv=%b rr=%b rd=%h want 1 0 00c3", i,
                 host.rsp_valid, host.req_ready, host.rsp_data);
      end
      @(negedge clk);
    end
    result = 16'h0D0D;
    take_rsp("bp");
    n_cmp++;
    if ({host.req_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_not_early: req_ready=%b busy=%b want 1 0", host.req_ready, busy);
    end
    exp_q.push_back({1'b0, 16'h0D0D});
    @(negedge clk);
    host.req_valid = 1'b0;
    cur_x = 16'h0200;
    n_cmp++;
    if ({busy, xin} !== {1'b1, 16'h0200}) begin
      n_err++;
      $display("FAIL bp_accept: busy=%b xin=%h want 1 0200", busy, xin);
    end
    wait_rsp(200, cyc);
    take_rsp("bp_next");
  endtask

  task automatic test_timeout();
    int cyc;
    mode = 0;
    done = 1'b1;
    exp_q.push_back({1'b1, 16'h0000});
    issue(16'h0300);
    wait_start_fall();
    wait_rsp(TO + 20, cyc);
    n_cmp++;
    if (cyc !== TO) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TO);
    end
    take_rsp("timeout");
    run_normal(16'h0101, 16'h00B2, "after_timeout");
  endtask

  task automatic test_busy_unit();
    int cyc;
    mode   = 0;
    done   = 1'b0;
    result = 16'h0077;
    exp_q.push_back({1'b0, 16'h0077});
    issue(16'h0033);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({start, busy} !== 2'b01) begin
        n_err++;
        $display("FAIL sync_hold[%0d]: start=%b busy=%b want 0 1", i, start, busy);
      end
      @(negedge clk);
    end
    done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (start !== 1'b1) begin
      n_err++;
      $display("FAIL sync_release: start=%b want 1", start);
    end
    wait_start_fall();
    done = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    wait_rsp(50, cyc);
    take_rsp("busy_unit");
  endtask

  task automatic test_reset_mid_run();
    mode   = 1;
    result = 16'h0055;
    issue(16'h0044);
    wait_start_fall();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({start, host.rsp_valid, busy, xin, host.rsp_data} !== {1'b0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      n_err++;
      $display("FAIL midrun_async: start=%b rv=%b busy=%b xin=%h rd=%h want 0 0 0 0 0",
               start, host.rsp_valid, busy, xin, host.rsp_data);
    end
    @(negedge clk);
    rst  = 1'b1;
    mph  = 0;
    done = 1'b1;
    #1;
    n_cmp++;
    if (host.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_ready: req_ready=%b want 1", host.req_ready);
    end
  endtask

`ifdef MACLAURIN_ISSUER_STATS_EN
  task automatic test_stats();
    int cyc;
    n_cmp++;
    if ({jobs_done, jobs_timeout} !== 32'h0) begin
      n_err++;
      $display("FAIL stats_reset: done=%0d timeout=%0d want 0 0", jobs_done, jobs_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      run_normal(16'(16'h0400 + i), 16'(16'h0010 + i), "stats");
    end
    mode = 0;
    done = 1'b1;
    exp_q.push_back({1'b1, 16'h0000});
    issue(16'h0500);
    wait_rsp(TO + 40, cyc);
    take_rsp("stats_timeout");
    n_cmp++;
    if ({jobs_done, jobs_timeout} !== {16'd3, 16'd1}) begin
      n_err++;
      $display("FAIL stats_count: done=%0d timeout=%0d want 3 1", jobs_done, jobs_timeout);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    host.req_valid = 1'b0;
    host.req_x     = '0;
    host.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_busy_unit();
    test_reset_mid_run();
`ifdef MACLAURIN_ISSUER_STATS_EN
    test_stats();
`endif
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d responses outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
